pseudo_linear_trainer: RTL

Parametrised, multi-cycle successor to the single-class pseudo-linear neuron for the MNIST Boolean-circuit learner. It holds an `N_IN`-bit parameter mask `p` and classifies one binary sample per transaction by comparing popcounts. In train mode it applies the reverse-derivative flip rule to `p`. Population counts and parameter updates are processed `CHUNK` bits per cycle, so width scales without one giant combinational popcount. Ten instances (one per class) sit behind the sample streamer.

---
 rtl/pseudo_linear_pkg.sv | 33 +++
 rtl/popcount_chunk.sv | 24 ++
 rtl/pseudo_linear_trainer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pseudo_linear_pkg.sv
// pseudo_linear_pkg
//   Shared types and helpers for the pseudo-linear neuron family.
//   - state_t      : transaction FSM states of the multi-cycle trainer
//   - count_width  : width needed to hold a count from 0 to n inclusive
//   - forward      : the neuron's forward rule (np >> thr) < n, unsigned
//   forward() takes its operands at fixed package widths so that the
//   single-class neuron and the trainer share one definition; callers
//   zero-extend their narrower counters into it. FWD_CW therefore bounds
//   the supported feature width to below 2**FWD_CW.
package pseudo_linear_pkg;

   localparam int FWD_CW    = 16;
   localparam int FWD_THR_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_EVAL,
      ST_UPDATE,
      ST_RESP
   } state_t;

   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic logic forward(input logic [FWD_CW-1:0]    n,
                                    input logic [FWD_CW-1:0]    np,
                                    input logic [FWD_THR_W-1:0] thr);
      return (np >> thr) < n;
   endfunction

endpackage

// File: rtl/popcount_chunk.sv
// popcount_chunk
//   Purely combinational population count of one CHUNK-bit slice.
//   Ports:
//     bits  in  CHUNK                 : slice to count
//     count out count_width(CHUNK)    : number of set bits in the slice
module popcount_chunk
   import pseudo_linear_pkg::*;
#(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0]              bits,
   output logic [count_width(CHUNK)-1:0] count
);

   localparam int PW = count_width(CHUNK);

   always_comb begin
      count = '0;
      for (int i = 0; i < CHUNK; i++) begin
         count = count + PW'(bits[i]);
      end
   end

endmodule

// File: rtl/pseudo_linear_trainer.sv
// pseudo_linear_trainer
//   Multi-cycle single-class pseudo-linear neuron with in-place training.
//   Holds an N_IN-bit parameter mask p, classifies one binary sample per
//   transaction by comparing popcounts, and in train mode applies the
//   reverse-derivative flip rule to p. All popcount and update work is
//   done CHUNK bits per cycle.
//   Ports:
//     clk, rst_n              : clock, asynchronous active-low reset
//     mode_train, threshold   : train/infer select and np shift, sampled at accept
//     p_clear                 : clear p, honoured only while idle
//     in_valid/in_ready       : sample handshake (in_x, in_label)
//     out_valid/out_ready     : result handshake (out_result, out_error, out_flips)
//     busy                    : a transaction is in flight
//     pm                      : current parameter mask
module pseudo_linear_trainer
   import pseudo_linear_pkg::*;
#(
   parameter int N_IN  = 784,
   parameter int CHUNK = 16,
   parameter int THR_W = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mode_train,
   input  logic [THR_W-1:0]             threshold,
   input  logic                         p_clear,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [N_IN-1:0]              in_x,
   input  logic                         in_label,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_result,
   output logic                         out_error,
   output logic [count_width(N_IN)-1:0] out_flips,
   output logic                         busy,
   output logic [N_IN-1:0]              pm
);

   localparam int CW = count_width(N_IN);
   localparam int C  = N_IN / CHUNK;
   localparam int IW = (C > 1) ? $clog2(C) : 1;
   localparam int PW = count_width(CHUNK);

   localparam logic [IW-1:0] LAST_IDX = IW'(C - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t state, state_nxt;

   logic [N_IN-1:0]  p_reg, x_reg;
   logic             label_reg, mode_reg, result_reg, error_reg;
   logic [THR_W-1:0] thr_reg;
   logic [CW-1:0]    n_cnt, np_cnt, flip_cnt;
   logic [IW-1:0]    idx;

   logic [CHUNK-1:0] p_chunk, x_chunk, px_chunk, upd_chunk;
   logic [PW-1:0]    pc_and, pc_p;
   logic [CW-1:0]    chunk_flips, n_r, np_r;
   logic             flip_bit, fwd_now, last_chunk;

   // Slice of p and x addressed by the shared chunk index. The same index
   // walks the chunks during COUNT and again during UPDATE.
   always_comb begin
      p_chunk    = p_reg[idx*CHUNK +: CHUNK];
      x_chunk    = x_reg[idx*CHUNK +: CHUNK];
      px_chunk   = p_chunk & x_chunk;
      last_chunk = (idx == LAST_IDX);
      fwd_now    = forward(FWD_CW'(n_cnt), FWD_CW'(np_cnt), FWD_THR_W'(thr_reg));
   end

   popcount_chunk #(.CHUNK(CHUNK)) u_pc_and (
      .bits  (px_chunk),
      .count (pc_and)
   );

   popcount_chunk #(.CHUNK(CHUNK)) u_pc_p (
      .bits  (p_chunk),
      .count (pc_p)
   );

   // Flip rule for the current chunk. Every bit sees the same frozen n and
   // np, so bits are independent and the whole chunk resolves in one cycle.
   // A bit flips when toggling it alone would change the forward output.
   always_comb begin
      upd_chunk   = p_chunk;
      chunk_flips = '0;
      n_r         = n_cnt;
      np_r        = np_cnt;
      flip_bit    = 1'b0;
      for (int b = 0; b < CHUNK; b++) begin
         n_r = n_cnt;
         if (x_chunk[b]) begin
            n_r = p_chunk[b] ? (n_cnt - CNT_ONE) : (n_cnt + CNT_ONE);
         end
         np_r         = p_chunk[b] ? (np_cnt - CNT_ONE) : (np_cnt + CNT_ONE);
         flip_bit     = result_reg ^ forward(FWD_CW'(n_r), FWD_CW'(np_r), FWD_THR_W'(thr_reg));
         upd_chunk[b] = p_chunk[b] ^ flip_bit;
         chunk_flips  = chunk_flips + CW'(flip_bit);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs. p_clear blocks acceptance so a clear
   // and a sample can never land on the same edge.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            busy     = 1'b0;
            in_ready = !p_clear;
            if (in_valid && !p_clear) begin
               state_nxt = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (last_chunk) begin
               state_nxt = ST_EVAL;
            end
         end
         ST_EVAL: begin
            state_nxt = (mode_reg && (fwd_now ^ label_reg)) ? ST_UPDATE : ST_RESP;
         end
         ST_UPDATE: begin
            if (last_chunk) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: sample latch, chunked accumulation, evaluation and the
   // in-place parameter update. Reset discards any partial update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_reg      <= '0;
         x_reg      <= '0;
         label_reg  <= 1'b0;
         mode_reg   <= 1'b0;
         thr_reg    <= '0;
         n_cnt      <= '0;
         np_cnt     <= '0;
         flip_cnt   <= '0;
         idx        <= '0;
         result_reg <= 1'b0;
         error_reg  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (p_clear) begin
                  p_reg <= '0;
               end else if (in_valid) begin
                  x_reg     <= in_x;
                  label_reg <= in_label;
                  mode_reg  <= mode_train;
                  thr_reg   <= threshold;
                  n_cnt     <= '0;
                  np_cnt    <= '0;
                  flip_cnt  <= '0;
                  idx       <= '0;
               end
            end
            ST_COUNT: begin
               n_cnt  <= n_cnt + CW'(pc_and);
               np_cnt <= np_cnt + CW'(pc_p);
               idx    <= last_chunk ? '0 : (idx + IW'(1));
            end
            ST_EVAL: begin
               result_reg <= fwd_now;
               error_reg  <= fwd_now ^ label_reg;
            end
            ST_UPDATE: begin
               p_reg[idx*CHUNK +: CHUNK] <= upd_chunk;
               flip_cnt                  <= flip_cnt + chunk_flips;
               idx                       <= last_chunk ? '0 : (idx + IW'(1));
            end
            default: begin
            end
         endcase
      end
   end

   assign out_result = result_reg;
   assign out_error  = error_reg;
   assign out_flips  = flip_cnt;
   assign pm         = p_reg;

endmodule
